branch_resolve_unit: RTL and testbench

Parametrised ID-stage branch resolver with optional dynamic prediction; successor to the single-mode equality comparator, target adder and flush control. Evaluates BEQ/BNE/BLT/BGE on signed operands, computes target and fall-through, and compares the real outcome against the prediction the instruction carried from IF. On mismatch it issues a registered redirect and IF/ID flush. It also owns the branch history/target table that IF reads for prediction.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_compare.sv | 31 +++
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared encodings and counter helpers for the branch resolver
//
// Holds the id_op encoding, the 2-bit prediction counter type and its
// reset/saturation constants, and the saturating counter update function.
package branch_pkg;

  localparam logic [1:0] OP_BEQ = 2'b00;
  localparam logic [1:0] OP_BNE = 2'b01;
  localparam logic [1:0] OP_BLT = 2'b10;
  localparam logic [1:0] OP_BGE = 2'b11;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_WEAK_NT = 2'b01;
  localparam bht_cnt_t CNT_MAX     = 2'b11;

  // Saturating 2-bit update: up on taken, down on not-taken.
  function automatic bht_cnt_t cnt_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_MAX) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - signed branch condition evaluator
//
// Purpose: combinational outcome of BEQ/BNE/BLT/BGE on signed operands.
// Ports:
//   op    in  2       branch opcode (OP_BEQ/OP_BNE/OP_BLT/OP_BGE)
//   rs    in  DATA_W  first signed operand
//   rt    in  DATA_W  second signed operand
//   taken out 1       branch condition holds
module branch_compare
  import branch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              [1:0]        op,
  input  logic signed       [DATA_W-1:0] rs,
  input  logic signed       [DATA_W-1:0] rt,
  output logic                           taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (rs == rt);
      OP_BNE:  taken = (rs != rt);
      OP_BLT:  taken = (rs < rt);
      OP_BGE:  taken = (rs >= rt);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch resolver with optional prediction table
//
// Purpose: resolves the branch in ID, detects mispredictions against the
// prediction carried from IF, issues a registered redirect + IF/ID flush,
// counts mispredicts and (with BRANCH_PREDICT_EN defined) owns the 2-bit
// counter / target table that IF reads combinationally.
// Configuration macro: BRANCH_PREDICT_EN (undefined: static not-taken,
// pred_taken/pred_target tied to 0).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_pc                      fetch PC for table lookup
//   pred_taken, pred_target    combinational prediction for if_pc
//   id_valid, id_op, id_pc     branch in ID, opcode, PC
//   id_offset                  signed PC-relative offset
//   id_rs, id_rt               signed operands
//   id_pred_taken/_target      prediction carried from IF
//   id_stall                   hold resolution until operands arrive
//   redirect_valid/_pc         registered fetch redirect
//   ifid_flush                 registered IF/ID squash
//   mispredict_cnt             saturating mispredict count
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              id_valid,
  input  logic [1:0]        id_op,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_offset,
  input  logic [DATA_W-1:0] id_rs,
  input  logic [DATA_W-1:0] id_rt,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pred_target,
  input  logic              id_stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic              taken;
  logic              resolve;
  logic              mispredict;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] fallthru;
  logic [ADDR_W-1:0] corrected_pc;

  branch_compare #(
    .DATA_W(DATA_W)
  ) u_compare (
    .op    (id_op),
    .rs    (id_rs),
    .rt    (id_rt),
    .taken (taken)
  );

  assign target       = id_pc + id_offset;
  assign fallthru     = id_pc + ADDR_W'(1);
  assign corrected_pc = taken ? target : fallthru;

  // While a redirect is in flight the ID instruction is wrong-path.
  assign resolve = id_valid & ~id_stall & ~redirect_valid;

  assign mispredict = (taken != id_pred_taken) ||
                      (taken && id_pred_taken && (id_pred_target != target));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      ifid_flush     <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      redirect_valid <= resolve & mispredict;
      ifid_flush     <= resolve & mispredict;
      if (resolve && mispredict) begin
        redirect_pc <= corrected_pc;
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

`ifdef BRANCH_PREDICT_EN
  bht_cnt_t          bht_cnt [BHT_DEPTH];
  logic [ADDR_W-1:0] bht_tgt [BHT_DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              unused_if_pc;

  assign rd_idx       = if_pc[IDX_W-1:0];
  assign wr_idx       = id_pc[IDX_W-1:0];
  assign unused_if_pc = ^if_pc;

  // Lookup reads the registered table, so a same-index update in this
  // cycle is only visible from the next cycle on.
  assign pred_taken  = bht_cnt[rd_idx][1];
  assign pred_target = bht_tgt[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_cnt[i] <= CNT_WEAK_NT;
        bht_tgt[i] <= '0;
      end
    end else if (resolve) begin
      bht_cnt[wr_idx] <= cnt_next(bht_cnt[wr_idx], taken);
      if (taken) bht_tgt[wr_idx] <= target;
    end
  end
`else
  logic             unused_if_pc;
  logic [IDX_W-1:0] unused_idx;

  assign unused_if_pc = ^if_pc;
  assign unused_idx   = if_pc[IDX_W-1:0];
  assign pred_taken   = 1'b0;
  assign pred_target  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    if_pc;
  logic          pred_taken;
  logic [7:0]    pred_target;
  logic          id_valid;
  logic [1:0]    id_op;
  logic [7:0]    id_pc;
  logic [7:0]    id_offset;
  logic [7:0]    id_rs;
  logic [7:0]    id_rt;
  logic          id_pred_taken;
  logic [7:0]    id_pred_target;
  logic          id_stall;
  logic          redirect_valid;
  logic [7:0]    redirect_pc;
  logic          ifid_flush;
  logic [CW-1:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [7:0] last_pc = 8'h00;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DATA_W(8), .ADDR_W(8), .BHT_DEPTH(16), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .id_valid(id_valid), .id_op(id_op), .id_pc(id_pc), .id_offset(id_offset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_flush(ifid_flush), .mispredict_cnt(mispredict_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] pc, input logic [7:0] off,
                       input logic [7:0] rs, input logic [7:0] rt,
                       input logic pt, input logic [7:0] ptg);
    id_valid = 1'b1; id_stall = 1'b0;
    id_op = op; id_pc = pc; id_offset = off; id_rs = rs; id_rt = rt;
    id_pred_taken = pt; id_pred_target = ptg;
  endtask

  task automatic check_out(input string tag, input logic exp_r);
    check_eq({tag, ".redirect_valid"}, redirect_valid, exp_r);
    check_eq({tag, ".ifid_flush"}, ifid_flush, exp_r);
    check_eq({tag, ".redirect_pc"}, redirect_pc, last_pc);
    check_eq({tag, ".mispredict_cnt"}, mispredict_cnt, exp_cnt);
  endtask

  // One resolution; a redirect is followed by one idle cycle so the
  // pulse width is checked and the next resolution is legal.
  task automatic resolve(input string tag, input logic [1:0] op, input logic [7:0] pc,
                         input logic [7:0] off, input logic [7:0] rs, input logic [7:0] rt,
                         input logic pt, input logic [7:0] ptg,
                         input logic exp_r, input logic [7:0] exp_pc);
    @(negedge clk);
    drive(op, pc, off, rs, rt, pt, ptg);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    if (exp_r) begin
      last_pc = exp_pc;
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
    check_out(tag, exp_r);
    if (exp_r) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".pulse_end"}, redirect_valid, 1'b0);
    end
  endtask

  task automatic pred_chk(input string tag, input logic [7:0] pc,
                          input logic exp_t, input logic [7:0] exp_tg);
    if_pc = pc;
    #1;
    check_eq({tag, ".pred_taken"}, pred_taken, exp_t);
    check_eq({tag, ".pred_target"}, pred_target, exp_tg);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 8'h00;
    id_valid = 1'b0; id_op = 2'b00; id_pc = 8'h00; id_offset = 8'h00;
    id_rs = 8'h00; id_rt = 8'h00; id_pred_taken = 1'b0; id_pred_target = 8'h00;
    id_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0);
    pred_chk("reset", 8'h10, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, predicted not-taken; lookup of same index sees old value
    @(negedge clk);
    if_pc = 8'h10;
    drive(2'b00, 8'h10, 8'h04, 8'd5, 8'd5, 1'b0, 8'h00);
    #1;
    check_eq("beq.pre_update_pred", pred_taken, 1'b0);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    exp_cnt = 1; last_pc = 8'h14;
    check_out("beq", 1'b1);
    pred_chk("beq.post", 8'h10, PE, PE ? 8'h14 : 8'h00);
    @(posedge clk);
    #1;
    check_eq("beq.pulse_end", redirect_valid, 1'b0);

    // BLT -3 < 2 taken; the ID instruction during the redirect is wrong-path
    @(negedge clk);
    drive(2'b10, 8'h22, 8'h08, 8'hFD, 8'h02, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    exp_cnt = 2; last_pc = 8'h2A;
    check_out("blt", 1'b1);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    check_out("wrong_path", 1'b0);

    // BGE -3 >= 2 false, predicted not-taken: no redirect, pc held
    resolve("bge", 2'b11, 8'h33, 8'h08, 8'hFD, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00);

    // Repeated taken branch at 0x10; with the table the prediction is correct
    resolve("beq2", 2'b00, 8'h10, 8'h04, 8'd5, 8'd5, PE, PE ? 8'h14 : 8'h00, !PE, 8'h14);
    resolve("beq3", 2'b00, 8'h10, 8'h04, 8'd5, 8'd5, PE, PE ? 8'h14 : 8'h00, !PE, 8'h14);
    pred_chk("beq3", 8'h10, PE, PE ? 8'h14 : 8'h00);
    // Not-taken once: strong counter only weakens, prediction stays taken
    resolve("bne_nt", 2'b01, 8'h10, 8'h04, 8'd5, 8'd5, PE, PE ? 8'h14 : 8'h00, PE, 8'h11);
    pred_chk("bne_nt", 8'h10, PE, PE ? 8'h14 : 8'h00);
    // Correct direction but wrong predicted target still redirects
    resolve("bad_tgt", 2'b00, 8'h10, 8'h04, 8'd5, 8'd5, PE, PE ? 8'h99 : 8'h00, 1'b1, 8'h14);

    // PC wrap cases at 0xFF
    resolve("wrap_nt", 2'b01, 8'hFF, 8'h02, 8'd5, 8'd5, PE, 8'h00, PE, 8'h00);
    resolve("wrap_t", 2'b00, 8'hFF, 8'h02, 8'd5, 8'd5, 1'b0, 8'h00, 1'b1, 8'h01);
    pred_chk("wrap", 8'hFF, 1'b0, PE ? 8'h01 : 8'h00);

    // Stall holds a mispredicting branch for three cycles
    @(negedge clk);
    if_pc = 8'h05;
    drive(2'b00, 8'h05, 8'h03, 8'd1, 8'd1, 1'b0, 8'h00);
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out("stall", 1'b0);
      check_eq("stall.pred_taken", pred_taken, 1'b0);
      check_eq("stall.pred_target", pred_target, 8'h00);
    end
    @(negedge clk);
    id_stall = 1'b0;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    exp_cnt++; last_pc = 8'h08;
    check_out("unstall", 1'b1);
    check_eq("unstall.pred_taken", pred_taken, PE);
    check_eq("unstall.pred_target", pred_target, PE ? 8'h08 : 8'h00);

    // Reset during the redirect pulse
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_cnt = 0; last_pc = 8'h00;
    check_out("mid_reset", 1'b0);
    pred_chk("mid_reset", 8'h05, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the mispredict counter
    for (int i = 0; i < 17; i++) begin
      resolve("sat", 2'b00, 8'h40, 8'h01, 8'd7, 8'd7, 1'b0, 8'h00, 1'b1, 8'h41);
    end
    check_eq("sat.final", mispredict_cnt, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

`ifndef BRANCH_PREDICT_EN
  always @(negedge clk) begin
    if (rst_n && pred_taken !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL static.pred_taken: got %0b expected 0", pred_taken);
    end
  end
`endif

endmodule
